pcm_fifo_sched: RTL and testbench

// - Read-side scheduler for the left-channel PCM clock-crossing FIFO that feeds the delta-sigma modulator.
// - Issues one FIFO read per output-sample tick from a programmable clk divider.
// - Holds off reads until the FIFO reaches a start watermark; covers underflow by repeating or muting samples.
// - Presents one sample_out/sample_valid pair per tick, so the modulator sees an unbroken cadence.

---
 rtl/pcm_sched_pkg.sv | 19 +
 rtl/pcm_fifo_sched_fs_tick_gen.sv | 31 +++
 rtl/pcm_fifo_sched.sv | 144 ++++++++++++++
 tb/tb_pcm_fifo_sched.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pcm_sched_pkg.sv
// Shared definitions for the PCM FIFO read scheduler: state encoding and divider limits.
package pcm_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_PREFILL = 2'b01,
    ST_RUN     = 2'b10,
    ST_HOLD    = 2'b11
  } state_e;

  localparam int              DIV_W   = 16;
  localparam logic [DIV_W-1:0] MIN_DIV = 16'd3;

  // Divider values below MIN_DIV would leave too few cycles between reads.
  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] div);
    return (div < MIN_DIV) ? MIN_DIV : div;
  endfunction

endpackage

// File: rtl/pcm_fifo_sched_fs_tick_gen.sv
// Output-sample tick generator: counts while running, ticks once every clamp(div)+1 cycles.
module fs_tick_gen
  import pcm_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_run,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] w_eff_div;

  assign w_eff_div = clamp_div(i_div);

  // Compare with >= so a divider lowered mid-count ticks once instead of wrapping through 2^16.
  assign o_tick = i_run && (r_cnt >= w_eff_div);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!i_run || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pcm_fifo_sched.sv
// Read-side scheduler for the left-channel PCM FIFO feeding the delta-sigma modulator.
// Define PCM_SCHED_STATS_EN to add the ufl_cnt underflow-tick statistics port.
module pcm_fifo_sched
  import pcm_sched_pkg::*;
#(
  parameter int DW        = 32,
  parameter int LVLW      = 6,
  parameter int START_LVL = 10,
  parameter int RD_LAT    = 1,
  parameter int MUTE_UFL  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [DIV_W-1:0] fs_div,
  input  logic [LVLW-1:0]  fifo_rdusedw,
  input  logic [DW-1:0]    fifo_q,
  output logic             fifo_rd_en,
  output logic [DW-1:0]    sample_out,
  output logic             sample_valid,
  output logic [1:0]       state_o,
`ifdef PCM_SCHED_STATS_EN
  output logic [15:0]      ufl_cnt,
`endif
  output logic             underflow
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic              w_run;
  logic              w_tick_raw;
  logic              w_tick;
  logic              w_lvl_empty;
  logic              w_lvl_start;
  logic              w_rd;
  logic              w_ufl_entry;
  logic              w_cap;
  logic              w_fresh;
  logic [RD_LAT-1:0] r_vld_pipe;
  logic [RD_LAT-1:0] r_rd_pipe;
  logic [DW-1:0]     r_sample;
  logic [DW-1:0]     r_last_good;
  logic [DW-1:0]     w_sample_nxt;
  logic              r_underflow;

  assign w_run       = (r_state == ST_RUN) || (r_state == ST_HOLD);
  assign w_lvl_empty = (fifo_rdusedw == '0);
  assign w_lvl_start = (fifo_rdusedw >= LVLW'(START_LVL));

  fs_tick_gen u_tick_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_run  (w_run),
    .i_div  (fs_div),
    .o_tick (w_tick_raw)
  );

  // A falling enable overrides a coincident tick: no read, no pipeline entry.
  assign w_tick      = w_tick_raw && enable;
  assign w_rd        = w_tick && (r_state == ST_RUN) && !w_lvl_empty;
  assign w_ufl_entry = w_tick && (r_state == ST_RUN) && w_lvl_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: the default assignment first keeps every path driven, so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    if (!enable) begin
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE:    w_state_nxt = ST_PREFILL;
        ST_PREFILL: if (w_lvl_start) w_state_nxt = ST_RUN;
        ST_RUN:     if (w_ufl_entry) w_state_nxt = ST_HOLD;
        ST_HOLD:    if (w_lvl_start) w_state_nxt = ST_RUN;
        default:    w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Tail of the pipeline lines up with fifo_q becoming valid RD_LAT cycles after the tick.
  assign w_cap        = r_vld_pipe[RD_LAT-1] && enable;
  assign w_fresh      = r_rd_pipe[RD_LAT-1];
  assign w_sample_nxt = w_fresh ? fifo_q : ((MUTE_UFL != 0) ? '0 : r_last_good);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe  <= '0;
      r_rd_pipe   <= '0;
      r_sample    <= '0;
      r_last_good <= '0;
      r_underflow <= 1'b0;
    end else if (!enable) begin
      r_vld_pipe  <= '0;
      r_rd_pipe   <= '0;
      r_sample    <= '0;
      r_last_good <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_vld_pipe <= (r_vld_pipe << 1) | RD_LAT'(w_tick);
      r_rd_pipe  <= (r_rd_pipe << 1) | RD_LAT'(w_rd);
      if (w_cap) begin
        r_sample <= w_sample_nxt;
        if (w_fresh) begin
          r_last_good <= fifo_q;
        end
      end
      if (r_state == ST_IDLE) begin
        r_underflow <= 1'b0;
      end else if (w_ufl_entry) begin
        r_underflow <= 1'b1;
      end
    end
  end

`ifdef PCM_SCHED_STATS_EN
  logic [15:0] r_ufl_cnt;

  // Counts every tick that delivers no fresh FIFO word; survives enable toggles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ufl_cnt <= '0;
    end else if (w_tick && ((r_state == ST_HOLD) || w_ufl_entry) && (r_ufl_cnt != 16'hFFFF)) begin
      r_ufl_cnt <= r_ufl_cnt + 16'd1;
    end
  end

  assign ufl_cnt = r_ufl_cnt;
`endif

  // The captured word is presented in its valid cycle, then held until the next one.
  assign sample_out   = w_cap ? w_sample_nxt : r_sample;
  assign sample_valid = w_cap;
  assign fifo_rd_en   = w_rd;
  assign state_o      = r_state;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_pcm_fifo_sched.sv
// Self-checking bench for pcm_fifo_sched: cycle model of tick cadence plus a sample scoreboard.
`timescale 1ns/1ps
module tb_pcm_fifo_sched;
  import pcm_sched_pkg::*;

  localparam int DW        = 32;
  localparam int LVLW      = 6;
  localparam int START_LVL = 10;
  localparam int RD_LAT    = 1;
  localparam int MUTE_UFL  = 0;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            enable;
  logic [15:0]     fs_div;
  logic [LVLW-1:0] fifo_rdusedw;
  logic [DW-1:0]   fifo_q = '0;
  logic            fifo_rd_en;
  logic [DW-1:0]   sample_out;
  logic            sample_valid;
  logic [1:0]      state_o;
  logic            underflow;
`ifdef PCM_SCHED_STATS_EN
  logic [15:0]     ufl_cnt;
`endif

  pcm_fifo_sched #(
    .DW(DW), .LVLW(LVLW), .START_LVL(START_LVL), .RD_LAT(RD_LAT), .MUTE_UFL(MUTE_UFL)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .fs_div       (fs_div),
    .fifo_rdusedw (fifo_rdusedw),
    .fifo_q       (fifo_q),
    .fifo_rd_en   (fifo_rd_en),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .state_o      (state_o),
`ifdef PCM_SCHED_STATS_EN
    .ufl_cnt      (ufl_cnt),
`endif
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];

  // Reference model state, owned by the monitor.
  state_e        m_state     = ST_IDLE;
  int            m_next_tick = -1;
  int            m_period    = 0;
  bit            m_uflag     = 1'b0;
  logic [DW-1:0] m_sample    = '0;
  logic [DW-1:0] m_last      = '0;
  int            m_ufl       = 0;
  int            rd_total    = 0;
  bit            q_pend      = 1'b0;
  logic [DW-1:0] q_val       = '0;

  // Data source control, owned by the stimulus: next read returns word_base + (reads since rd_mark).
  logic [DW-1:0] word_base = 32'h100;
  int            rd_mark   = 0;

  initial begin : monitor
    exp_t          e;
    bit            tick;
    bit            exp_rd;
    bit            exp_v;
    logic [DW-1:0] d;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_state  = ST_IDLE;
        sb.delete();
        m_uflag  = 1'b0;
        m_sample = '0;
        m_last   = '0;
        m_ufl    = 0;
      end else begin
        tick = enable && ((m_state == ST_RUN) || (m_state == ST_HOLD)) && (cyc == m_next_tick);
        if (!enable) sb.delete();
        exp_rd = tick && (m_state == ST_RUN) && (fifo_rdusedw != 0);
        check("fifo_rd_en", 32'(fifo_rd_en), 32'(exp_rd));
        if (tick) begin
          if (exp_rd) begin
            d        = word_base + DW'(rd_total - rd_mark);
            rd_total = rd_total + 1;
            m_last   = d;
            q_val    = d;
            q_pend   = 1'b1;
          end else begin
            d = (MUTE_UFL != 0) ? '0 : m_last;
            if (m_ufl != 65535) m_ufl = m_ufl + 1;
          end
          sb.push_back('{cyc + RD_LAT, d});
          m_next_tick = cyc + m_period;
        end
        exp_v = (sb.size() > 0) && (sb[0].due == cyc);
        check("sample_valid", 32'(sample_valid), 32'(exp_v));
        if (exp_v) begin
          e        = sb.pop_front();
          m_sample = e.data;
        end
        check("sample_out", sample_out, m_sample);
        check("state_o", 32'(state_o), 32'(m_state));
        check("underflow", 32'(underflow), 32'(m_uflag));
`ifdef PCM_SCHED_STATS_EN
        check("ufl_cnt", 32'(ufl_cnt), 32'(m_ufl));
`endif
        if (!enable) begin
          m_state  = ST_IDLE;
          m_uflag  = 1'b0;
          m_sample = '0;
          m_last   = '0;
        end else begin
          case (m_state)
            ST_IDLE: m_state = ST_PREFILL;
            ST_PREFILL: if (fifo_rdusedw >= START_LVL) begin
              m_state     = ST_RUN;
              m_period    = ((fs_div < 16'd3) ? 3 : int'(fs_div)) + 1;
              m_next_tick = cyc + m_period;
            end
            ST_RUN: if (tick && (fifo_rdusedw == 0)) begin
              m_state = ST_HOLD;
              m_uflag = 1'b1;
            end
            ST_HOLD: if (fifo_rdusedw >= START_LVL) m_state = ST_RUN;
            default: m_state = ST_IDLE;
          endcase
        end
      end
      @(posedge clk);
      #1;
      if (q_pend) begin
        fifo_q = q_val;
        q_pend = 1'b0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns just after the edge that starts the next modelled tick cycle.
  task automatic wait_tick(input string tag);
    int guard = 0;
    while ((cyc != m_next_tick) && (guard < 1000)) begin
      step(1);
      guard++;
    end
    if (cyc != m_next_tick) check(tag, 32'(cyc), 32'(m_next_tick));
  endtask

  initial begin : stimulus
    rst_n        = 1'b0;
    enable       = 1'b0;
    fs_div       = 16'd99;
    fifo_rdusedw = '0;
    step(3);
    check("reset_state", 32'(state_o), 32'(ST_IDLE));
    check("reset_sample", sample_out, '0);
    rst_n = 1'b1;
    step(2);

    // Prefill ramp: stays in PREFILL until the level reaches START_LVL.
    enable = 1'b1;
    for (int l = 0; l <= 12; l++) begin
      fifo_rdusedw = LVLW'(l);
      step(2);
    end
    wait_tick("prefill_tick1_timeout");
    step(1);
    wait_tick("prefill_tick2_timeout");
    step(1);

    // Drop enable exactly on a tick cycle.
    wait_tick("abort_tick_timeout");
    enable = 1'b0;
    step(3);

    // Clamped divider cadence with the sequence 1,2,3...
    word_base    = 32'd1;
    rd_mark      = rd_total;
    fs_div       = 16'd2;
    fifo_rdusedw = 6'd12;
    enable       = 1'b1;
    step(45);

    // Underflow after a final good sample of 0x1234.
    wait_tick("ufl_arm_timeout");
    word_base = 32'h1234;
    rd_mark   = rd_total;
    step(1);
    fifo_rdusedw = '0;
    for (int k = 0; k < 5; k++) begin
      wait_tick("ufl_tick_timeout");
      step(1);
    end
    word_base    = 32'h1235;
    rd_mark      = rd_total;
    fifo_rdusedw = 6'd10;
    step(12);
    enable = 1'b0;
    step(2);
    enable = 1'b1;
    step(30);

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_rd_en", 32'(fifo_rd_en), '0);
    check("rst_valid", 32'(sample_valid), '0);
    check("rst_sample", sample_out, '0);
    check("rst_state", 32'(state_o), 32'(ST_IDLE));
    check("rst_underflow", 32'(underflow), '0);
`ifdef PCM_SCHED_STATS_EN
    check("rst_ufl_cnt", 32'(ufl_cnt), '0);
`endif
    step(2);
    enable = 1'b0;
    rst_n  = 1'b1;
    step(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
